// File: rtl/bx_cmd_scheduler_if.sv
// Booking channel between the two command requesters and the BC scheduler.
// Requesters strobe a target BC; the scheduler returns ready and a one-cycle grant.
interface bx_cmd_scheduler_if #(
  parameter int BC_W = 12
);
  logic            req_a_i;
  logic [BC_W-1:0] bc_a_i;
  logic            rdy_a_o;
  logic            gnt_a_o;
  logic            req_b_i;
  logic [BC_W-1:0] bc_b_i;
  logic            rdy_b_o;
  logic            gnt_b_o;

  modport master (
    output req_a_i, bc_a_i, req_b_i, bc_b_i,
    input  rdy_a_o, gnt_a_o, rdy_b_o, gnt_b_o
  );

  modport slave (
    input  req_a_i, bc_a_i, req_b_i, bc_b_i,
    output rdy_a_o, gnt_a_o, rdy_b_o, gnt_b_o
  );
endinterface

// File: rtl/bx_cmd_scheduler.sv
// BC/orbit timebase plus a two-requester one-slot-per-booking command scheduler.
// Grants are combinational from registered state; ready drops while a booking is pending.
module bx_cmd_scheduler #(
  parameter int LSB_CNT_MAX = 3564,
  parameter int BC_W        = 12,
  parameter int ORBIT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                bc0_i,
  bx_cmd_scheduler_if.slave   bk,
  output logic [BC_W-1:0]     bc_cnt_o,
  output logic [ORBIT_W-1:0]  orbit_cnt_o,
  output logic                orbit_o,
  output logic                synced_o,
  output logic                resync_err_o,
  output logic                bad_bc_o,
  output logic                coll_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(LSB_CNT_MAX - 1);
  localparam logic [BC_W:0]   BC_LIMIT = (BC_W + 1)'(LSB_CNT_MAX);

  state_t          state;
  logic            pend_a, pend_b;
  logic [BC_W-1:0] tgt_a, tgt_b;
  logic            run, elig_a, elig_b, wrap;
  logic            ok_a, ok_b, book_a, book_b;

  assign run    = (state == RUN);
  assign elig_a = run & pend_a & (bc_cnt_o == tgt_a);
  assign elig_b = run & pend_b & (bc_cnt_o == tgt_b);
  assign wrap   = bc0_i | (bc_cnt_o == BC_LAST);

  assign ok_a   = ({1'b0, bk.bc_a_i} < BC_LIMIT);
  assign ok_b   = ({1'b0, bk.bc_b_i} < BC_LIMIT);
  assign book_a = run & bk.req_a_i & ~pend_a;
  assign book_b = run & bk.req_b_i & ~pend_b;

  assign bk.gnt_a_o = elig_a;
  assign bk.gnt_b_o = elig_b & ~elig_a;
  assign bk.rdy_a_o = ~pend_a;
  assign bk.rdy_b_o = ~pend_b;
  assign orbit_o    = run & (bc_cnt_o == '0);
  assign synced_o   = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bc_cnt_o     <= '0;
      orbit_cnt_o  <= '0;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      tgt_a        <= '0;
      tgt_b        <= '0;
      resync_err_o <= 1'b0;
      bad_bc_o     <= 1'b0;
      coll_o       <= 1'b0;
    end else if (!en_i) begin
      // Disable dominates everything, including a coincident bc0_i.
      state        <= IDLE;
      bc_cnt_o     <= '0;
      orbit_cnt_o  <= '0;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      resync_err_o <= 1'b0;
      bad_bc_o     <= 1'b0;
      coll_o       <= 1'b0;
    end else if (!run) begin
      bc_cnt_o     <= '0;
      orbit_cnt_o  <= '0;
      resync_err_o <= 1'b0;
      bad_bc_o     <= 1'b0;
      coll_o       <= 1'b0;
      if (bc0_i) state <= RUN;
    end else begin
      if (wrap) begin
        bc_cnt_o    <= '0;
        orbit_cnt_o <= orbit_cnt_o + 1'b1;
      end else begin
        bc_cnt_o    <= bc_cnt_o + 1'b1;
      end
      resync_err_o <= bc0_i & (bc_cnt_o != BC_LAST);
      bad_bc_o     <= (book_a & ~ok_a) | (book_b & ~ok_b);
      coll_o       <= elig_a & elig_b;

      // A booking needs ~pend and a grant needs pend, so these never collide.
      if (book_a && ok_a) begin
        pend_a <= 1'b1;
        tgt_a  <= bk.bc_a_i;
      end else if (bk.gnt_a_o) begin
        pend_a <= 1'b0;
      end
      if (book_b && ok_b) begin
        pend_b <= 1'b1;
        tgt_b  <= bk.bc_b_i;
      end else if (bk.gnt_b_o) begin
        pend_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bx_cmd_scheduler.sv
// Directed bench for bx_cmd_scheduler: stimulus pushes expected pulse events,
// a negedge monitor pops and compares every pulse the DUT raises.
module tb_bx_cmd_scheduler;
  localparam int LSB_CNT_MAX = 3564;
  localparam int BC_W        = 12;
  localparam int ORBIT_W     = 16;

  localparam int EV_RESYNC = 0;
  localparam int EV_BAD    = 1;
  localparam int EV_COLL   = 2;
  localparam int EV_GNT_A  = 3;
  localparam int EV_GNT_B  = 4;

  typedef struct {
    int kind;
    int bc;
    int orb;
  } ev_t;

  logic clk;
  logic rst_n;
  logic en_i;
  logic bc0_i;
  logic [BC_W-1:0]    bc_cnt_o;
  logic [ORBIT_W-1:0] orbit_cnt_o;
  logic orbit_o, synced_o, resync_err_o, bad_bc_o, coll_o;

  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];

  bx_cmd_scheduler_if #(.BC_W(BC_W)) bk ();

  bx_cmd_scheduler #(
    .LSB_CNT_MAX(LSB_CNT_MAX),
    .BC_W(BC_W),
    .ORBIT_W(ORBIT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en_i),
    .bc0_i(bc0_i),
    .bk(bk),
    .bc_cnt_o(bc_cnt_o),
    .orbit_cnt_o(orbit_cnt_o),
    .orbit_o(orbit_o),
    .synced_o(synced_o),
    .resync_err_o(resync_err_o),
    .bad_bc_o(bad_bc_o),
    .coll_o(coll_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int bc, input int orb);
    ev_t e;
    e.kind = kind;
    e.bc   = bc;
    e.orb  = orb;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at bc %0d orbit %0d expected none",
               kind, bc_cnt_o, orbit_cnt_o);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.bc != int'(bc_cnt_o) || e.orb != int'(orbit_cnt_o)) begin
        errors++;
        $display("FAIL event: got kind %0d bc %0d orbit %0d expected kind %0d bc %0d orbit %0d",
                 kind, bc_cnt_o, orbit_cnt_o, e.kind, e.bc, e.orb);
      end
    end
  endtask

  // Pulses in one cycle are examined in a fixed order; pushes follow it.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resync_err_o) see(EV_RESYNC);
      if (bad_bc_o)     see(EV_BAD);
      if (coll_o)       see(EV_COLL);
      if (bk.gnt_a_o)   see(EV_GNT_A);
      if (bk.gnt_b_o)   see(EV_GNT_B);
    end
  end

  initial begin
    rst_n = 1'b0;
    en_i  = 1'b0;
    bc0_i = 1'b0;
    bk.req_a_i = 1'b0;
    bk.bc_a_i  = '0;
    bk.req_b_i = 1'b0;
    bk.bc_b_i  = '0;
    #12;
    chk("rst_bc_cnt", bc_cnt_o, 0);
    chk("rst_orbit_cnt", orbit_cnt_o, 0);
    chk("rst_synced", synced_o, 0);
    chk("rst_orbit_o", orbit_o, 0);
    chk("rst_rdy_a", bk.rdy_a_o, 1);
    chk("rst_rdy_b", bk.rdy_b_o, 1);
    chk("rst_gnt", {bk.gnt_a_o, bk.gnt_b_o}, 0);
    rst_n = 1'b1;
    step(1);

    // Sync and walk one full orbit.
    en_i = 1'b1; bc0_i = 1'b1;
    step(1);
    bc0_i = 1'b0;
    chk("sync_synced", synced_o, 1);
    chk("sync_bc0", bc_cnt_o, 0);
    chk("sync_orbit_o", orbit_o, 1);
    for (int i = 1; i < LSB_CNT_MAX; i++) begin
      step(1);
      chk("walk_bc", bc_cnt_o, i);
    end
    step(1);
    chk("wrap_bc", bc_cnt_o, 0);
    chk("wrap_orbit_cnt", orbit_cnt_o, 1);
    chk("wrap_orbit_o", orbit_o, 1);

    // Misaligned then aligned bc0.
    step(100);
    bc0_i = 1'b1;
    push(EV_RESYNC, 0, 2);
    step(1);
    bc0_i = 1'b0;
    chk("resync_bc", bc_cnt_o, 0);
    chk("resync_orbit", orbit_cnt_o, 2);
    step(LSB_CNT_MAX - 1);
    chk("pre_aligned_bc", bc_cnt_o, LSB_CNT_MAX - 1);
    bc0_i = 1'b1;
    step(1);
    bc0_i = 1'b0;
    chk("aligned_bc", bc_cnt_o, 0);
    chk("aligned_orbit", orbit_cnt_o, 3);

    // A books BC 50 at BC 10.
    step(10);
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd50;
    push(EV_GNT_A, 50, 3);
    step(1);
    bk.req_a_i = 1'b0;
    chk("book_rdy_a_low", bk.rdy_a_o, 0);
    step(39);
    chk("gnt_a_at_50", bk.gnt_a_o, 1);
    step(1);
    chk("gnt_a_single", bk.gnt_a_o, 0);
    chk("rdy_a_back_51", bk.rdy_a_o, 1);

    // A and B collide on BC 200.
    step(100);
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd200;
    bk.req_b_i = 1'b1; bk.bc_b_i = 12'd200;
    push(EV_GNT_A, 200, 3);
    push(EV_COLL, 201, 3);
    push(EV_GNT_B, 200, 4);
    step(1);
    bk.req_a_i = 1'b0; bk.req_b_i = 1'b0;
    step(48);
    chk("coll_gnt_a", bk.gnt_a_o, 1);
    chk("coll_gnt_b_blocked", bk.gnt_b_o, 0);
    step(1);
    chk("coll_pulse", coll_o, 1);
    chk("coll_rdy_b_low", bk.rdy_b_o, 0);
    step(LSB_CNT_MAX - 1);
    chk("late_gnt_b", bk.gnt_b_o, 1);
    chk("late_gnt_b_orbit", orbit_cnt_o, 4);
    step(1);
    chk("rdy_b_back", bk.rdy_b_o, 1);

    // Out-of-range target.
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd3564;
    push(EV_BAD, 202, 4);
    step(1);
    bk.req_a_i = 1'b0;
    chk("bad_rdy_a", bk.rdy_a_o, 1);
    step(2 * LSB_CNT_MAX);
    chk("bad_rdy_a_later", bk.rdy_a_o, 1);
    chk("bad_orbit_after", orbit_cnt_o, 6);

    // Disable drops a pending booking.
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd500;
    step(1);
    bk.req_a_i = 1'b0;
    chk("pend500_rdy_a", bk.rdy_a_o, 0);
    step(97);
    chk("dis_at_300", bc_cnt_o, 300);
    en_i = 1'b0;
    step(1);
    chk("dis_synced", synced_o, 0);
    chk("dis_bc", bc_cnt_o, 0);
    chk("dis_orbit", orbit_cnt_o, 0);
    chk("dis_rdy_a", bk.rdy_a_o, 1);
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd7;
    step(2);
    bk.req_a_i = 1'b0;
    chk("idle_ignores_book", bk.rdy_a_o, 1);
    step(600);

    // Target one ahead of capture is granted immediately.
    en_i = 1'b1; bc0_i = 1'b1;
    step(1);
    bc0_i = 1'b0;
    chk("resync2_synced", synced_o, 1);
    step(5);
    bk.req_a_i = 1'b1; bk.bc_a_i = 12'd6;
    push(EV_GNT_A, 6, 0);
    step(1);
    bk.req_a_i = 1'b0;
    chk("immediate_gnt_a", bk.gnt_a_o, 1);
    step(1);
    chk("immediate_rdy_a", bk.rdy_a_o, 1);

    // en_i low beats a coincident bc0_i.
    en_i = 1'b0; bc0_i = 1'b1;
    step(1);
    chk("en_wins_synced", synced_o, 0);
    chk("en_wins_bc", bc_cnt_o, 0);
    en_i = 1'b1;
    step(1);
    bc0_i = 1'b0;
    chk("resync3_synced", synced_o, 1);

    // Asynchronous reset mid-orbit.
    step(20);
    bk.req_b_i = 1'b1; bk.bc_b_i = 12'd1000;
    step(1);
    bk.req_b_i = 1'b0;
    chk("pre_rst_rdy_b", bk.rdy_b_o, 0);
    chk("pre_rst_bc", bc_cnt_o, 21);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bc", bc_cnt_o, 0);
    chk("arst_synced", synced_o, 0);
    chk("arst_rdy_b", bk.rdy_b_o, 1);
    chk("arst_orbit_o", orbit_o, 0);
    chk("arst_pulses", {resync_err_o, bad_bc_o, coll_o, bk.gnt_a_o, bk.gnt_b_o}, 0);
    #20;
    rst_n = 1'b1;
    step(3);
    chk("events_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
